// File: rtl/cart_spi_rom.sv
// cart_spi_rom: cartridge-side ROM responder for the boy core bus.
// ROM reads (a[15]=0) are served by fetching one byte from SPI flash with a
// single-bit 0x03 READ transaction; reads with a[15]=1 return 8'hFF at once.
// Optional MBC1-style banking is enabled by defining CART_SPI_ROM_MBC1_EN;
// without it the cartridge behaves as a flat 32 KiB ROM and writes are ignored.
module cart_spi_rom #(
  parameter logic [23:0] FLASH_BASE = 24'h100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  dout,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  din,
  output logic        busy,
  output logic        valid,
  output logic        flash_sck,
  output logic        flash_ssb,
  output logic        flash_io0,
  input  logic        flash_io1
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEL       = 3'd1,
    ST_SHIFT_OUT = 3'd2,
    ST_SHIFT_IN  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;

`ifdef CART_SPI_ROM_MBC1_EN
  // Map a ROM bus address to a cartridge byte offset using the bank registers.
  function automatic logic [23:0] rom_offset(input logic [15:0] addr,
                                             input logic [1:0]  hi,
                                             input logic [4:0]  lo);
    logic [23:0] off;
    if (addr[14] == 1'b1) begin
      off = {3'b000, hi, lo, addr[13:0]};
    end else begin
      off = {10'b0, addr[13:0]};
    end
    return off;
  endfunction
`else
  // Flat 32 KiB ROM: the low 15 address bits are the offset.
  function automatic logic [23:0] rom_offset(input logic [14:0] addr);
    return {9'b0, addr};
  endfunction
`endif

  // Strobe synchronisation and edge detection
  logic        rd_r;
  logic        rd_prev_r;
  logic        rd_edge_s;

  // FSM and datapath state
  state_t      state_r;
  state_t      state_nxt_s;
  logic [23:0] addr_r;
  logic [23:0] addr_nxt_s;
  logic [30:0] shreg_r;
  logic [30:0] shreg_nxt_s;
  logic [7:0]  rx_r;
  logic [7:0]  rx_nxt_s;
  logic [4:0]  bit_cnt_r;
  logic [4:0]  bit_cnt_nxt_s;
  logic        phase_r;
  logic        phase_nxt_s;
  logic [31:0] cmd_s;
  logic [23:0] offset_s;

  // Next values of the registered outputs
  logic [7:0]  din_nxt_s;
  logic        valid_nxt_s;
  logic        sck_nxt_s;
  logic        ssb_nxt_s;
  logic        io0_nxt_s;

  // Register rd once so edge detection sees a clean synchronous signal.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_r      <= 1'b0;
      rd_prev_r <= 1'b0;
    end else begin
      rd_r      <= rd;
      rd_prev_r <= rd_r;
    end
  end

  assign rd_edge_s = rd_r & ~rd_prev_r;

`ifdef CART_SPI_ROM_MBC1_EN
  logic       wr_r;
  logic       wr_prev_r;
  logic       wr_edge_s;
  logic [4:0] bank_lo_r;
  logic [1:0] bank_hi_r;

  // Register wr once so edge detection sees a clean synchronous signal.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_r      <= 1'b0;
      wr_prev_r <= 1'b0;
    end else begin
      wr_r      <= wr;
      wr_prev_r <= wr_r;
    end
  end

  assign wr_edge_s = wr_r & ~wr_prev_r;

  // Bank registers: updated on any wr edge regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_lo_r <= 5'd1;
      bank_hi_r <= 2'd0;
    end else if (wr_edge_s) begin
      case (a[15:13])
        3'b001: begin
          bank_lo_r <= (dout[4:0] == 5'd0) ? 5'd1 : dout[4:0];
        end
        3'b010: begin
          bank_hi_r <= dout[1:0];
        end
        default: begin
          bank_lo_r <= bank_lo_r;
          bank_hi_r <= bank_hi_r;
        end
      endcase
    end else begin
      bank_lo_r <= bank_lo_r;
      bank_hi_r <= bank_hi_r;
    end
  end

  // A read that coincides with a write sees the registers before the update.
  assign offset_s = rom_offset(a, bank_hi_r, bank_lo_r);
`else
  // Write strobe and data have no function in a ROM-only cartridge.
  logic unused_wr_s;
  assign unused_wr_s = ^{wr, dout};
  assign offset_s    = rom_offset(a[14:0]);
`endif

  assign cmd_s = {CMD_READ, addr_r};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-output logic for the SPI READ sequence.
  always_comb begin
    state_nxt_s   = state_r;
    addr_nxt_s    = addr_r;
    shreg_nxt_s   = shreg_r;
    rx_nxt_s      = rx_r;
    bit_cnt_nxt_s = bit_cnt_r;
    phase_nxt_s   = phase_r;
    din_nxt_s     = din;
    valid_nxt_s   = 1'b0;
    sck_nxt_s     = 1'b0;
    ssb_nxt_s     = flash_ssb;
    io0_nxt_s     = flash_io0;
    case (state_r)
      ST_IDLE: begin
        ssb_nxt_s = 1'b1;
        io0_nxt_s = 1'b0;
        if (rd_edge_s) begin
          if (a[15] == 1'b0) begin
            addr_nxt_s  = FLASH_BASE + offset_s;
            state_nxt_s = ST_SEL;
          end else begin
            din_nxt_s   = 8'hFF;
            valid_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEL: begin
        // First command bit goes out with chip select so it is stable
        // before the first rising SCK.
        ssb_nxt_s     = 1'b0;
        io0_nxt_s     = cmd_s[31];
        shreg_nxt_s   = cmd_s[30:0];
        bit_cnt_nxt_s = 5'd0;
        phase_nxt_s   = 1'b0;
        state_nxt_s   = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        ssb_nxt_s = 1'b0;
        if (phase_r == 1'b0) begin
          sck_nxt_s   = 1'b1;
          phase_nxt_s = 1'b1;
        end else begin
          sck_nxt_s   = 1'b0;
          phase_nxt_s = 1'b0;
          shreg_nxt_s = {shreg_r[29:0], 1'b0};
          if (bit_cnt_r == 5'd31) begin
            bit_cnt_nxt_s = 5'd0;
            io0_nxt_s     = 1'b0;
            state_nxt_s   = ST_SHIFT_IN;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 5'd1;
            io0_nxt_s     = shreg_r[30];
          end
        end
      end
      ST_SHIFT_IN: begin
        ssb_nxt_s = 1'b0;
        io0_nxt_s = 1'b0;
        if (phase_r == 1'b0) begin
          // MISO is taken on the same clk that raises SCK.
          sck_nxt_s   = 1'b1;
          phase_nxt_s = 1'b1;
          rx_nxt_s    = {rx_r[6:0], flash_io1};
        end else begin
          sck_nxt_s   = 1'b0;
          phase_nxt_s = 1'b0;
          if (bit_cnt_r == 5'd7) begin
            bit_cnt_nxt_s = 5'd0;
            state_nxt_s   = ST_DONE;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 5'd1;
          end
        end
      end
      ST_DONE: begin
        ssb_nxt_s   = 1'b1;
        io0_nxt_s   = 1'b0;
        din_nxt_s   = rx_r;
        valid_nxt_s = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        ssb_nxt_s   = 1'b1;
        io0_nxt_s   = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r    <= 24'h000000;
      shreg_r   <= 31'h00000000;
      rx_r      <= 8'h00;
      bit_cnt_r <= 5'd0;
      phase_r   <= 1'b0;
      din       <= 8'hFF;
      busy      <= 1'b0;
      valid     <= 1'b0;
      flash_sck <= 1'b0;
      flash_ssb <= 1'b1;
      flash_io0 <= 1'b0;
    end else begin
      addr_r    <= addr_nxt_s;
      shreg_r   <= shreg_nxt_s;
      rx_r      <= rx_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      phase_r   <= phase_nxt_s;
      din       <= din_nxt_s;
      busy      <= (state_nxt_s != ST_IDLE);
      valid     <= valid_nxt_s;
      flash_sck <= sck_nxt_s;
      flash_ssb <= ssb_nxt_s;
      flash_io0 <= io0_nxt_s;
    end
  end

endmodule

// File: tb/tb_cart_spi_rom.sv
// Self-checking bench for cart_spi_rom: a behavioural SPI flash model plus a
// table of bus operations with hand-computed flash addresses, followed by
// hand-written sequences for busy-drop and reset-mid-read.
module tb_cart_spi_rom;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic [15:0] a    = 16'h0000;
  logic [7:0]  dout = 8'h00;
  logic        wr   = 1'b0;
  logic        rd   = 1'b0;
  logic [7:0]  din;
  logic        busy;
  logic        valid;
  logic        flash_sck;
  logic        flash_ssb;
  logic        flash_io0;
  logic        flash_io1 = 1'b0;

  int checks   = 0;
  int failures = 0;

  cart_spi_rom #(.FLASH_BASE(24'h100000)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .dout      (dout),
    .wr        (wr),
    .rd        (rd),
    .din       (din),
    .busy      (busy),
    .valid     (valid),
    .flash_sck (flash_sck),
    .flash_ssb (flash_ssb),
    .flash_io0 (flash_io0),
    .flash_io1 (flash_io1)
  );

  always #5 clk = ~clk;

  // Flash contents: one known byte, a hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [23:0] ad);
    if (ad == 24'h100150) return 8'hC3;
    else return ad[7:0] ^ ad[15:8] ^ ad[23:16] ^ 8'hA5;
  endfunction

  // SPI flash model (mode 0): capture 32 command bits, then return one byte.
  logic [31:0] fl_cmd    = 32'h0;
  int          fl_cnt    = 0;
  int          cmd_count = 0;
  logic [7:0]  last_op   = 8'h00;
  logic [23:0] last_addr = 24'h0;
  logic [7:0]  fl_byte;
  assign fl_byte = mem_byte(last_addr);

  always @(posedge flash_sck or posedge flash_ssb) begin
    if (flash_ssb) begin
      fl_cnt <= 0;
    end else begin
      if (fl_cnt < 32) fl_cmd <= {fl_cmd[30:0], flash_io0};
      if (fl_cnt == 31) begin
        last_op   <= fl_cmd[30:23];
        last_addr <= {fl_cmd[22:0], flash_io0};
        cmd_count <= cmd_count + 1;
      end
      fl_cnt <= fl_cnt + 1;
    end
  end

  always @(negedge flash_sck) begin
    if (!flash_ssb && fl_cnt >= 32 && fl_cnt < 40) flash_io1 <= fl_byte[39 - fl_cnt];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Raise rd (optionally wr too) and wait, bounded, for valid.
  task automatic do_read(input logic [15:0] addr, input logic also_wr, input logic [7:0] wdata,
                         output int lat, output logic [7:0] din_cap,
                         output logic busy_sel, output logic ssb_low);
    @(negedge clk);
    a  = addr;
    rd = 1'b1;
    if (also_wr) begin
      dout = wdata;
      wr   = 1'b1;
    end
    lat = -1; din_cap = 8'h00; busy_sel = 1'b0; ssb_low = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 2) busy_sel = busy;
      if (flash_ssb == 1'b0) ssb_low = 1'b1;
      if (valid == 1'b1) begin
        lat     = n - 1;
        din_cap = din;
        break;
      end
    end
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    a = addr; dout = data; wr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
  endtask

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_RDWR} op_t;
  typedef struct {
    op_t         op;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        mapped;
    logic [23:0] exp_addr;
  } vec_t;

  initial begin
    vec_t       vq[$];
    int         lat;
    int         c0;
    int         vcount;
    logic [7:0] din_cap;
    logic [7:0] exp_din;
    logic       busy_sel;
    logic       ssb_low;

    // Operation table: reads carry the expected flash address.
    vq.push_back('{OP_RD,   16'h0150, 8'h00, 1'b1, 24'h100150});
    vq.push_back('{OP_RD,   16'h0000, 8'h00, 1'b1, 24'h100000});
    vq.push_back('{OP_RD,   16'hC000, 8'h00, 1'b0, 24'h000000});
`ifdef CART_SPI_ROM_MBC1_EN
    vq.push_back('{OP_RD,   16'h4000, 8'h00, 1'b1, 24'h104000});
    vq.push_back('{OP_WR,   16'h2000, 8'h00, 1'b0, 24'h000000});
    vq.push_back('{OP_RD,   16'h4000, 8'h00, 1'b1, 24'h104000});
    vq.push_back('{OP_WR,   16'h4000, 8'h02, 1'b0, 24'h000000});
    vq.push_back('{OP_WR,   16'h2100, 8'h03, 1'b0, 24'h000000});
    vq.push_back('{OP_RD,   16'h7FFF, 8'h00, 1'b1, 24'h20FFFF});
    vq.push_back('{OP_RD,   16'h0150, 8'h00, 1'b1, 24'h100150});
    vq.push_back('{OP_WR,   16'h3FFF, 8'h1F, 1'b0, 24'h000000});
    vq.push_back('{OP_RD,   16'h4001, 8'h00, 1'b1, 24'h27C001});
    vq.push_back('{OP_WR,   16'h6000, 8'h00, 1'b0, 24'h000000});
    vq.push_back('{OP_RD,   16'h4001, 8'h00, 1'b1, 24'h27C001});
    vq.push_back('{OP_WR,   16'h5000, 8'hFF, 1'b0, 24'h000000});
    vq.push_back('{OP_RD,   16'h7FFF, 8'h00, 1'b1, 24'h2FFFFF});
    vq.push_back('{OP_RDWR, 16'h4000, 8'h00, 1'b1, 24'h2FC000});
    vq.push_back('{OP_RD,   16'h4000, 8'h00, 1'b1, 24'h17C000});
`else
    vq.push_back('{OP_WR,   16'h2000, 8'h05, 1'b0, 24'h000000});
    vq.push_back('{OP_RD,   16'h4000, 8'h00, 1'b1, 24'h104000});
    vq.push_back('{OP_RD,   16'h7FFF, 8'h00, 1'b1, 24'h107FFF});
    vq.push_back('{OP_WR,   16'h4000, 8'h02, 1'b0, 24'h000000});
    vq.push_back('{OP_RD,   16'h5555, 8'h00, 1'b1, 24'h105555});
`endif

    // Reset for two clocks, then the idle outputs must hold their reset values.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_din",   {24'h0, din}, 32'hFF);
      check("reset_busy",  {31'h0, busy}, 32'h0);
      check("reset_valid", {31'h0, valid}, 32'h0);
      check("reset_ssb",   {31'h0, flash_ssb}, 32'h1);
      check("reset_sck",   {31'h0, flash_sck}, 32'h0);
    end

    // Table-driven operations.
    foreach (vq[i]) begin
      if (vq[i].op == OP_WR) begin
        do_write(vq[i].addr, vq[i].data);
      end else begin
        c0 = cmd_count;
        do_read(vq[i].addr, (vq[i].op == OP_RDWR), vq[i].data, lat, din_cap, busy_sel, ssb_low);
        exp_din = vq[i].mapped ? mem_byte(vq[i].exp_addr) : 8'hFF;
        check($sformatf("latency[%0d]", i), lat, vq[i].mapped ? 32'd83 : 32'd1);
        check($sformatf("din[%0d]", i), {24'h0, din_cap}, {24'h0, exp_din});
        check($sformatf("busy_sel[%0d]", i), {31'h0, busy_sel}, {31'h0, vq[i].mapped});
        check($sformatf("cmd_delta[%0d]", i), cmd_count - c0, vq[i].mapped ? 32'd1 : 32'd0);
        if (vq[i].mapped) begin
          check($sformatf("flash_addr[%0d]", i), {8'h0, last_addr}, {8'h0, vq[i].exp_addr});
          check($sformatf("opcode[%0d]", i), {24'h0, last_op}, 32'h03);
        end else begin
          check($sformatf("ssb_untouched[%0d]", i), {31'h0, ssb_low}, 32'h0);
        end
        @(negedge clk);
        check($sformatf("valid_one_cycle[%0d]", i), {31'h0, valid}, 32'h0);
        check($sformatf("din_held[%0d]", i), {24'h0, din}, {24'h0, exp_din});
        check($sformatf("busy_after[%0d]", i), {31'h0, busy}, 32'h0);
        check($sformatf("ssb_after[%0d]", i), {31'h0, flash_ssb}, 32'h1);
        repeat (2) @(negedge clk);
      end
    end

    // Busy drop: a second rd edge at cycle 40 must be ignored.
    c0 = cmd_count;
    lat = -1;
    din_cap = 8'h00;
    @(negedge clk);
    a = 16'h0150; rd = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 38) rd = 1'b0;
      if (n == 41) begin
        a = 16'h0200; rd = 1'b1;
      end
      if (valid) begin
        lat = n - 1; din_cap = din;
        break;
      end
    end
    rd = 1'b0;
    vcount = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("drop_latency", lat, 32'd83);
    check("drop_din", {24'h0, din_cap}, 32'hC3);
    check("drop_cmd_count", cmd_count - c0, 32'd1);
    check("drop_addr", {8'h0, last_addr}, 32'h100150);
    check("drop_no_second_valid", vcount, 32'd0);

    // Reset at cycle 50 of a read: bus released, no valid, din back to FF.
    @(negedge clk);
    a = 16'h0150; rd = 1'b1;
    for (int n = 1; n <= 51; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_ssb_low", {31'h0, flash_ssb}, 32'h0);
    rst = 1'b1; rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ssb",   {31'h0, flash_ssb}, 32'h1);
    check("rst_mid_sck",   {31'h0, flash_sck}, 32'h0);
    check("rst_mid_valid", {31'h0, valid}, 32'h0);
    check("rst_mid_din",   {24'h0, din}, 32'hFF);
    check("rst_mid_busy",  {31'h0, busy}, 32'h0);
    rst = 1'b0;
    vcount = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("rst_mid_no_valid", vcount, 32'd0);
    check("rst_mid_din_hold", {24'h0, din}, 32'hFF);

    // A normal read after the aborted one.
    c0 = cmd_count;
    do_read(16'h0150, 1'b0, 8'h00, lat, din_cap, busy_sel, ssb_low);
    check("post_rst_latency", lat, 32'd83);
    check("post_rst_din", {24'h0, din_cap}, 32'hC3);
    check("post_rst_addr", {8'h0, last_addr}, 32'h100150);
    check("post_rst_cmd_count", cmd_count - c0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
